// File: rtl/seq_addsub_chunked_if.sv
// rtl/seq_addsub_chunked_if.sv - start/busy/done operand and result bundle for seq_addsub_chunked
interface seq_addsub_chunked_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, A, B, sel,
        input  busy, done, S, cout, ovf, zero
    );

    modport slave (
        input  start, A, B, sel,
        output busy, done, S, cout, ovf, zero
    );
endinterface

// File: rtl/seq_addsub_chunked.sv
// rtl/seq_addsub_chunked.sv - multi-cycle add/subtract, CHUNK bits per clock with carry, C/V/Z flags
module seq_addsub_chunked #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic clk,
    input logic rst_n,
    seq_addsub_chunked_if.slave io
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_next;
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic             busy_r, done_r, cout_r, ovf_r, zero_r;
    logic [WIDTH-1:0] s_r;

    logic [CHUNK-1:0] slice_a, slice_b, slice_sum;
    logic [CHUNK:0]   slice_ext;
    logic             last, accept, msb_cin;
    int               base;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = (idx == IDXW'(NCHUNK - 1));
        base       = int'(idx) * CHUNK;
        slice_a    = op_a[base +: CHUNK];
        slice_b    = op_b[base +: CHUNK];
        slice_ext  = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
        slice_sum  = slice_ext[CHUNK-1:0];
        // sum bit = a ^ b ^ cin, so the carry into the top bit falls out without a second adder
        msb_cin    = slice_sum[CHUNK-1] ^ slice_a[CHUNK-1] ^ slice_b[CHUNK-1];
        acc_next   = acc;
        acc_next[base +: CHUNK] = slice_sum;
        case (state)
            IDLE: if (io.start) begin
                state_next = RUN;
                accept     = 1'b1;
            end
            RUN:  if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= 1'b0;
            if (accept) begin
                op_a   <= io.A;
                op_b   <= io.sel ? ~io.B : io.B;
                carry  <= io.sel;
                idx    <= '0;
                busy_r <= 1'b1;
            end else if (state == RUN) begin
                acc   <= acc_next;
                carry <= slice_ext[CHUNK];
                if (last) begin
                    idx    <= '0;
                    s_r    <= acc_next;
                    cout_r <= slice_ext[CHUNK];
                    ovf_r  <= msb_cin ^ slice_ext[CHUNK];
                    zero_r <= (acc_next == '0);
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign io.busy = busy_r;
    assign io.done = done_r;
    assign io.S    = s_r;
    assign io.cout = cout_r;
    assign io.ovf  = ovf_r;
    assign io.zero = zero_r;
endmodule

// File: tb/tb_seq_addsub_chunked.sv
// tb/tb_seq_addsub_chunked.sv - directed and reference-model bench for seq_addsub_chunked
module tb_seq_addsub_chunked;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_addsub_chunked_if #(.WIDTH(32)) bus ();
    seq_addsub_chunked_if #(.WIDTH(32)) b32 ();
    seq_addsub_chunked_if #(.WIDTH(32)) b1 ();

    assign b32.start = bus.start;
    assign b32.A     = bus.A;
    assign b32.B     = bus.B;
    assign b32.sel   = bus.sel;
    assign b1.start  = bus.start;
    assign b1.A      = bus.A;
    assign b1.B      = bus.B;
    assign b1.sel    = bus.sel;

    seq_addsub_chunked #(.WIDTH(32), .CHUNK(8))  dut   (.clk(clk), .rst_n(rst_n), .io(bus));
    seq_addsub_chunked #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .rst_n(rst_n), .io(b32));
    seq_addsub_chunked #(.WIDTH(32), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .io(b1));

    logic [2:0]  dn;
    logic [31:0] sv [3];
    logic [2:0]  fl [3];
    assign dn    = {b1.done, b32.done, bus.done};
    assign sv[0] = bus.S;
    assign sv[1] = b32.S;
    assign sv[2] = b1.S;
    assign fl[0] = {bus.cout, bus.ovf, bus.zero};
    assign fl[1] = {b32.cout, b32.ovf, b32.zero};
    assign fl[2] = {b1.cout, b1.ovf, b1.zero};

    int vectors = 0;
    int miscompares = 0;
    int exp_lat [3] = '{4, 1, 32};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.A = a;
        bus.B = b;
        bus.sel = s;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // result {S, cout, ovf, zero} computed at full width from the original operands
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [32:0] r;
        logic        v;
        if (s) begin
            r = {1'b0, a} - {1'b0, b};
            r[32] = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            r = {1'b0, a} + {1'b0, b};
            v = (a[31] == b[31]) && (r[31] != a[31]);
        end
        return {r[31:0], r[32], v, (r[31:0] == 32'd0)};
    endfunction

    task automatic run_all(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] es, input logic [2:0] ef);
        int          lat [3];
        int          cnt [3];
        logic [31:0] rs  [3];
        logic [2:0]  rf  [3];
        for (int k = 0; k < 3; k++) begin
            lat[k] = -1; cnt[k] = 0; rs[k] = 'x; rf[k] = 'x;
        end
        go(a, b, s);
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " early done"}, 32'(bus.done), 32'd0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (dn[k]) begin
                    cnt[k]++;
                    if (lat[k] < 0) begin
                        lat[k] = n; rs[k] = sv[k]; rf[k] = fl[k];
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s dut%0d latency", tag, k), lat[k], exp_lat[k]);
            chk($sformatf("%s dut%0d done count", tag, k), cnt[k], 32'd1);
            chk($sformatf("%s dut%0d S", tag, k), rs[k], es);
            chk($sformatf("%s dut%0d cvz", tag, k), 32'(rf[k]), 32'(ef));
        end
    endtask

    initial begin
        int          n, gap, cnt;
        logic [31:0] first_s, ra, rb;
        logic        hold_ok, rsel;
        logic [34:0] m;

        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset S", bus.S, 32'd0);
        chk("reset cvz", 32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_all("add ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 3'b010);
        run_all("add wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 3'b101);
        run_all("add mixed",  32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 3'b000);
        run_all("sub 5-7",    32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 3'b000);
        run_all("sub 7-7",    32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 3'b101);
        run_all("sub minneg", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 3'b110);

        // operands change after capture and a second start arrives while busy
        go(32'h11111111, 32'h22222222, 1'b0);
        bus.A = 32'hFFFFFFFF; bus.B = 32'hFFFFFFFF; bus.sel = 1'b1;
        @(negedge clk);
        go(32'h00000001, 32'h00000002, 1'b0);
        cnt = 0; first_s = 'x; n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                cnt++;
                if (cnt == 1) begin first_s = bus.S; n = i; end
            end
        end
        chk("busy-start done count", cnt, 32'd1);
        chk("busy-start done time", n, 32'd2);
        chk("busy-start S", first_s, 32'h33333333);

        // back-to-back: second start issued in the done cycle
        go(32'h0000000A, 32'h00000003, 1'b1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first done", 32'(bus.done), 32'd1);
        chk("b2b first S", bus.S, 32'h00000007);
        chk("b2b first cvz", 32'({bus.cout, bus.ovf, bus.zero}), 32'b100);
        go(32'h40000000, 32'h40000000, 1'b0);
        gap = 1;
        chk("b2b second accepted", 32'(bus.busy), 32'd1);
        hold_ok = (bus.S === 32'h00000007);
        while (!bus.done && gap < 20) begin
            @(negedge clk);
            gap++;
            if (!bus.done && bus.S !== 32'h00000007) hold_ok = 1'b0;
        end
        chk("b2b S held", 32'(hold_ok), 32'd1);
        chk("b2b gap", gap, 32'd5);
        chk("b2b second S", bus.S, 32'h80000000);
        chk("b2b second cvz", 32'({bus.cout, bus.ovf, bus.zero}), 32'b010);
        @(negedge clk);
        chk("done one cycle", 32'(bus.done), 32'd0);

        // reset two edges into an operation
        go(32'h01020304, 32'h01010101, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        chk("midreset S", bus.S, 32'd0);
        chk("midreset cvz", 32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("aborted op no done", cnt, 32'd0);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            rsel = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: ra = 32'h80000000;
                1: rb = 32'h7FFFFFFF;
                2: rb = ra;
                3: ra = 32'hFFFFFFFF;
                default: ;
            endcase
            m = model(ra, rb, rsel);
            go(ra, rb, rsel);
            n = 0;
            while (!bus.done && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("rand%0d latency", i), n, 32'd4);
            chk($sformatf("rand%0d S", i), bus.S, m[34:3]);
            chk($sformatf("rand%0d cvz", i), 32'({bus.cout, bus.ovf, bus.zero}), 32'(m[2:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
